// File: rtl/reduce_p24_pkg.sv
// Shared constants and fold helper for the p = 2^24 - 63 pseudo-Mersenne reducer.
// Optional canonical stage is enabled by defining REDUCE_CANON_EN.
package reduce_p24_pkg;

    localparam int IN_W    = 48;
    localparam int F1_W    = 30;
    localparam int OUT_W   = 25;
    localparam int FOLD_SH = 6;
    localparam int FOLD_C  = (1 << FOLD_SH) - 1;

    localparam logic [23:0] P24 = 24'd16777153;

    // 63*x without a multiplier: (x << 6) - x, result always fits in 30 bits.
    function automatic logic [F1_W-1:0] mul_fold_c(input logic [23:0] x);
        logic [F1_W-1:0] xe;
        xe = {{(F1_W-24){1'b0}}, x};
        return (xe << FOLD_SH) - xe;
    endfunction

endpackage

// File: rtl/reduce_p24_pipe.sv
// Two-stage fold pipeline (plus canonical stage under REDUCE_CANON_EN) with
// valid/ID sideband; every stage shifts together when en is high.
module reduce_p24_pipe
    import reduce_p24_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [ID_W-1:0]   in_id,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    logic             v1_q, v2_q;
    logic [ID_W-1:0]  id1_q, id2_q;
    logic [F1_W-1:0]  f1_q, f1_d;
    logic [OUT_W-1:0] f2_q, f2_d;

    always_comb begin
        f1_d = {{(F1_W-24){1'b0}}, in_data[23:0]} + mul_fold_c(in_data[IN_W-1:24]);
        f2_d = {1'b0, f1_q[23:0]} + OUT_W'(mul_fold_c({18'b0, f1_q[F1_W-1:24]}));
    end

    // NOTE: sequential state uses non-blocking assignments so every stage reads
    // the pre-edge value of its predecessor; blocking here would collapse stages.
    // NOTE: data registers are reset along with the valids because rsp_data must
    // read 0 after reset, not just be marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            id1_q <= '0;
            id2_q <= '0;
            f1_q  <= '0;
            f2_q  <= '0;
        end else if (en) begin
            v1_q  <= in_valid;
            id1_q <= in_id;
            f1_q  <= f1_d;
            v2_q  <= v1_q;
            id2_q <= id1_q;
            f2_q  <= f2_d;
        end
    end

`ifdef REDUCE_CANON_EN
    logic             v3_q;
    logic [ID_W-1:0]  id3_q;
    logic [OUT_W-1:0] f3_q, f3_d;

    always_comb begin
        f3_d = (f2_q >= {1'b0, P24}) ? f2_q - {1'b0, P24} : f2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q  <= 1'b0;
            id3_q <= '0;
            f3_q  <= '0;
        end else if (en) begin
            v3_q  <= v2_q;
            id3_q <= id2_q;
            f3_q  <= f3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_id    = id3_q;
    assign out_data  = f3_q;
    assign busy      = v1_q | v2_q | v3_q;
`else
    assign out_valid = v2_q;
    assign out_id    = id2_q;
    assign out_data  = f2_q;
    assign busy      = v1_q | v2_q;
`endif

endmodule

// File: rtl/reduce_p24_arbiter.sv
// Round-robin front end sharing one reduce_p24_pipe among NREQ requesters.
// Latency 2, or 3 when REDUCE_CANON_EN is defined.
module reduce_p24_arbiter
    import reduce_p24_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            adv;
    logic            take;
    logic [IN_W-1:0] sel_data;

    // NOTE: every signal is given a default before the scan so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        adv         = !rsp_valid || rsp_ready;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        take      = adv && grant_found;
        req_ready = take ? (NREQ'(1) << grant_idx) : '0;
        sel_data  = req_data[int'(grant_idx)*IN_W +: IN_W];
        rr_d      = rr_q;
        if (take) begin
            rr_d = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    reduce_p24_pipe #(.ID_W(ID_W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (take),
        .in_id     (grant_idx),
        .in_data   (sel_data),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_data  (rsp_data),
        .busy      (busy)
    );

endmodule

// File: tb/tb_reduce_p24_arbiter.sv
// Self-checking bench for reduce_p24_arbiter: slot-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_reduce_p24_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam longint P = 64'd16777153;
`ifdef REDUCE_CANON_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*48-1:0] req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [24:0]        rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int     id;
        longint data;
        int     cyc;
    } rsp_t;

    rsp_t rsp_log[$];
    int   grant_log[$];
    int   cycle = 0;

    always #5 clk = ~clk;

    reduce_p24_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Value the response must carry for operand c.
    function automatic longint expect_val(input longint c);
`ifdef REDUCE_CANON_EN
        return c % P;
`else
        longint f1;
        f1 = (c % (64'd1 << 24)) + 63 * (c / (64'd1 << 24));
        return (f1 % (64'd1 << 24)) + 63 * (f1 / (64'd1 << 24));
`endif
    endfunction

    // Reference model: LAT slots that all move together when the output is free.
    bit     m_v [LAT];
    int     m_id[LAT];
    longint m_d [LAT];
    int     rr_m = 0;
    bit     model_ok = 1'b0;

    always @(negedge clk) begin : monitor
        bit        adv;
        bit        any_v;
        int        g;
        int        dg;
        logic [NREQ-1:0] exp_ready;
        cycle++;
        adv = !m_v[LAT-1] || rsp_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr_m + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = (adv && g >= 0) ? NREQ'(1) << g : '0;
        any_v = 1'b0;
        for (int s = 0; s < LAT; s++) any_v |= m_v[s];
        if (model_ok) begin
            check("model req_ready", 64'(req_ready), 64'(exp_ready));
            check("model rsp_valid", 64'(rsp_valid), 64'(m_v[LAT-1]));
            check("model busy", 64'(busy), 64'(any_v));
            if (m_v[LAT-1]) begin
                check("model rsp_data", 64'(rsp_data), 64'(m_d[LAT-1]));
                check("model rsp_id", 64'(rsp_id), 64'(m_id[LAT-1]));
            end
        end
        if (model_ok && !rst) begin
            dg = -1;
            for (int k = 0; k < NREQ; k++) if (req_ready[k] && req_valid[k]) dg = k;
            if (dg >= 0) grant_log.push_back(dg);
            if (rsp_valid && rsp_ready)
                rsp_log.push_back('{id: int'(rsp_id), data: longint'(rsp_data), cyc: cycle});
        end
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                m_v[s] = 1'b0; m_id[s] = 0; m_d[s] = 0;
            end
            rr_m = 0;
            model_ok = 1'b1;
        end else if (adv) begin
            for (int s = LAT-1; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_id[s] = m_id[s-1]; m_d[s] = m_d[s-1];
            end
            m_v[0] = (g >= 0);
            m_id[0] = (g >= 0) ? g : 0;
            m_d[0] = (g >= 0) ? expect_val(longint'(req_data[g*48 +: 48])) : 0;
            if (g >= 0) rr_m = (g + 1) % NREQ;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input longint c);
        req_data[i*48 +: 48] = 48'(c);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [24:0] held;
        int          seen;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        check("reset rsp_id", 64'(rsp_id), 64'd0);
        rst = 1'b0;

        // Single request from requester 2, c = 2^24.
        set_op(2, 64'd1 << 24);
        req_valid = 4'b0100;
        #1;
        check("single req_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("single not early", 64'(rsp_valid), 64'd0);
        seen = 0;
        for (int n = 1; n < LAT + 3 && seen == 0; n++) begin
            tick();
            if (rsp_valid) seen = n;
        end
        check("single latency", 64'(seen), 64'(LAT - 1));
        check("single rsp_data", 64'(rsp_data), 64'd63);
        check("single rsp_id", 64'(rsp_id), 64'd2);
        tick();

        // Boundary operands back to back from requester 0.
        rsp_log.delete();
        grant_log.delete();
        req_valid = 4'b0001;
        set_op(0, 64'd16777153); tick();
        set_op(0, (64'd1 << 48) - 1); tick();
        set_op(0, 64'd0); tick();
        set_op(0, 64'd1 << 24); tick();
        req_valid = '0;
        for (int n = 0; n < LAT + 2; n++) tick();
        check("boundary count", 64'(rsp_log.size()), 64'd4);
        if (rsp_log.size() == 4) begin
`ifdef REDUCE_CANON_EN
            check("boundary p", 64'(rsp_log[0].data), 64'd0);
            check("boundary max", 64'(rsp_log[1].data), 64'd3968);
`else
            check("boundary p", 64'(rsp_log[0].data), 64'd16777153);
            check("boundary max", 64'(rsp_log[1].data), 64'd16781121);
`endif
            check("boundary zero", 64'(rsp_log[2].data), 64'd0);
            check("boundary 2^24", 64'(rsp_log[3].data), 64'd63);
            check("boundary id", 64'(rsp_log[3].id), 64'd0);
        end

        // Round robin, all four requesters for 8 cycles.
        do_reset();
        rsp_log.delete();
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, longint'(i + 1) * 64'h0000_9E37_79B9_7F4A);
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) tick();
        req_valid = '0;
        for (int n = 0; n < LAT + 2; n++) tick();
        check("rr grant count", 64'(grant_log.size()), 64'd8);
        check("rr rsp count", 64'(rsp_log.size()), 64'd8);
        if (grant_log.size() == 8 && rsp_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr grant order", 64'(grant_log[k]), 64'(k % 4));
                check("rr rsp_id order", 64'(rsp_log[k].id), 64'(k % 4));
                check("rr one per cycle", 64'(rsp_log[k].cyc - rsp_log[0].cyc), 64'(k));
            end
        end

        // Backpressure: rsp_ready low in stream cycles 5..9.
        do_reset();
        rsp_log.delete();
        grant_log.delete();
        req_valid = 4'b1111;
        held = '0;
        for (int n = 0; n < 16; n++) begin
            rsp_ready = !(n >= 5 && n <= 9);
            #1;
            if (n == 5) held = rsp_data;
            if (n >= 5 && n <= 9) begin
                check("stall req_ready", 64'(req_ready), 64'd0);
                check("stall rsp_valid", 64'(rsp_valid), 64'd1);
                check("stall rsp_data", 64'(rsp_data), 64'(held));
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < LAT + 3; n++) tick();
        check("bp accept count", 64'(grant_log.size()), 64'd11);
        check("bp rsp count", 64'(rsp_log.size()), 64'(grant_log.size()));
        if (grant_log.size() == 11 && rsp_log.size() == 11) begin
            for (int k = 0; k < 11; k++) begin
                check("bp grant order", 64'(grant_log[k]), 64'(k % 4));
                check("bp rsp order", 64'(rsp_log[k].id), 64'(k % 4));
                check("bp rsp value", 64'(rsp_log[k].data),
                      64'(expect_val(longint'(req_data[(k % 4)*48 +: 48]))));
            end
        end

        // Reset while entries are in flight.
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        tick();
        rsp_ready = 1'b0;
        tick();
        check("mid busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        req_valid = 4'b1010;
        tick();
        check("mid rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("mid rst first grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        for (int n = 0; n < LAT + 2; n++) tick();
        check("mid rst drained", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
